// File: rtl/encode83_pkg.sv
// Shared constants and helpers for the 8-to-3 request encoder.
package encode83_pkg;

  localparam int N_LINES = 8;
  localparam int CODE_W  = 3;

  function automatic logic [N_LINES-1:0] onehot(input logic [CODE_W-1:0] code);
    logic [N_LINES-1:0] mask;
    mask       = '0;
    mask[code] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/encode83_pick.sv
// Combinational selector, zero latency, no state. ENCODE83_RR_EN: walk upward from start+1;
// otherwise walk downward from start, so start = 7 gives highest-index-wins priority.
module encode83_pick
  import encode83_pkg::*;
(
  input  logic [N_LINES-1:0] avail,
  input  logic [CODE_W-1:0]  start,
  output logic [CODE_W-1:0]  sel,
  output logic               any
);

  logic [CODE_W-1:0] idx;

  always_comb begin
    sel = '0;
    any = 1'b0;
    idx = '0;
    for (int k = 0; k < N_LINES; k++) begin
`ifdef ENCODE83_RR_EN
      idx = start + CODE_W'(k) + CODE_W'(1);
`else
      idx = start - CODE_W'(k);
`endif
      if (!any && avail[idx]) begin
        sel = idx;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/encode83_req.sv
// Sticky 8-line request collector presenting one granted index per valid/ready handshake; code appears
// one cycle after a request sampled while the slot is free, and holds while ready is low (ENCODE83_RR_EN: round-robin).
module encode83_req
  import encode83_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_LINES-1:0] req,
  output logic [CODE_W-1:0]  code,
  output logic               valid,
  input  logic               ready,
  output logic [N_LINES-1:0] pending,
  output logic               busy
);

  logic [N_LINES-1:0] avail;
  logic               slot_free;
  logic [CODE_W-1:0]  start;
  logic [CODE_W-1:0]  sel;
  logic               any;

  assign avail     = pending | req;
  assign slot_free = !valid || ready;
  assign busy      = valid | (|pending);

`ifdef ENCODE83_RR_EN
  logic [CODE_W-1:0] last;

  assign start = last;

  // Reset value 7 makes the first search after reset begin at index 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= CODE_W'(N_LINES - 1);
    end else if (slot_free && any) begin
      last <= sel;
    end
  end
`else
  assign start = CODE_W'(N_LINES - 1);
`endif

  encode83_pick u_pick (
    .avail (avail),
    .start (start),
    .sel   (sel),
    .any   (any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code    <= '0;
      valid   <= 1'b0;
      pending <= '0;
    end else if (slot_free) begin
      if (any) begin
        code    <= sel;
        valid   <= 1'b1;
        pending <= avail & ~onehot(sel);
      end else begin
        valid   <= 1'b0;
        pending <= '0;
      end
    end else begin
      // Output stalled: fold new requests (including a re-request of code) into pending.
      pending <= avail;
    end
  end

  property p_hold_stable;
    @(posedge clk) disable iff (!rst_n) (valid && !ready) |=> (valid && $stable(code));
  endproperty
  a_hold_stable: assert property (p_hold_stable);

endmodule

// File: tb/tb_encode83_req.sv
// Scoreboard bench for encode83_req: expected codes queued at stimulus time, popped on each handshake.
module tb_encode83_req;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [2:0] code;
  logic       valid;
  logic       ready;
  logic [7:0] pending;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;
  logic [2:0] sb[$];

  encode83_req dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .code    (code),
    .valid   (valid),
    .ready   (ready),
    .pending (pending),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Handshake occurs on the next rising edge; inputs only change just after rising edges.
  always @(negedge clk) begin
    if (rst_n && valid && ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        chk("sb_code", 32'(code), 32'(sb.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    bit done;
    done = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!valid && pending == 8'h00) begin
        done = 1'b1;
        break;
      end
    end
    chk(tag, 32'(done), 32'd1);
    tick();
    ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req   = 8'hFF;
    ready = 1'b0;

    // Reset holds everything clear even with all requests asserted.
    repeat (2) @(negedge clk);
    chk("rst_code",    32'(code),    32'd0);
    chk("rst_valid",   32'(valid),   32'd0);
    chk("rst_pending", 32'(pending), 32'h00);
    chk("rst_busy",    32'(busy),    32'd0);

    tick();
    rst_n = 1'b1;
`ifdef ENCODE83_RR_EN
    for (int c = 0; c < 8; c++) sb.push_back(3'(c));
`else
    for (int c = 7; c >= 0; c--) sb.push_back(3'(c));
`endif
    tick();
    req = 8'h00;
    @(negedge clk);
    chk("rel_valid", 32'(valid), 32'd1);
`ifdef ENCODE83_RR_EN
    chk("rel_code",    32'(code),    32'd0);
    chk("rel_pending", 32'(pending), 32'hFE);
`else
    chk("rel_code",    32'(code),    32'd7);
    chk("rel_pending", 32'(pending), 32'h7F);
`endif
    drain("rel_drain");

    // Streaming: one-cycle burst of all lines, ready high, no bubbles.
`ifdef ENCODE83_RR_EN
    for (int c = 0; c < 8; c++) sb.push_back(3'(c));
`else
    for (int c = 7; c >= 0; c--) sb.push_back(3'(c));
`endif
    ready = 1'b1;
    req   = 8'hFF;
    tick();
    req = 8'h00;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("stream_valid", 32'(valid), 32'd1);
    end
    @(negedge clk);
    chk("stream_end", 32'(valid), 32'd0);
    tick();
    ready = 1'b0;

    // Pick under backpressure.
    req = 8'b0010_0100;
    tick();
    req = 8'h00;
`ifdef ENCODE83_RR_EN
    sb.push_back(3'd2);
    sb.push_back(3'd5);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_code",    32'(code),    32'd2);
      chk("bp_pending", 32'(pending), 32'h20);
    end
`else
    sb.push_back(3'd5);
    sb.push_back(3'd2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_code",    32'(code),    32'd5);
      chk("bp_pending", 32'(pending), 32'h04);
    end
`endif
    chk("bp_valid", 32'(valid), 32'd1);
    tick();
    ready = 1'b1;
    tick();
    @(negedge clk);
`ifdef ENCODE83_RR_EN
    chk("bp_second", 32'(code), 32'd5);
`else
    chk("bp_second", 32'(code), 32'd2);
`endif
    @(negedge clk);
    chk("bp_idle", 32'(valid), 32'd0);
    tick();
    ready = 1'b0;

    // Stability: code 3 held while a higher line arrives.
    req = 8'h08;
    tick();
    req = 8'h80;
    tick();
    req = 8'h00;
    sb.push_back(3'd3);
    sb.push_back(3'd7);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stab_code",    32'(code),    32'd3);
      chk("stab_pending", 32'(pending), 32'h80);
    end
    chk("stab_busy", 32'(busy), 32'd1);
    drain("stab_drain");

    // Re-request of the code currently held in the output register.
    req = 8'h08;
    tick();
    req = 8'h08;
    tick();
    req = 8'h00;
    sb.push_back(3'd3);
    sb.push_back(3'd3);
    @(negedge clk);
    chk("rereq_code",    32'(code),    32'd3);
    chk("rereq_pending", 32'(pending), 32'h08);
    drain("rereq_drain");

    // Asynchronous reset between edges discards everything outstanding.
    req = 8'h70;
    tick();
    req = 8'h00;
    @(negedge clk);
`ifdef ENCODE83_RR_EN
    chk("ar_pending", 32'(pending), 32'h60);
`else
    chk("ar_pending", 32'(pending), 32'h30);
`endif
    chk("ar_valid_pre", 32'(valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("ar_valid",   32'(valid),   32'd0);
    chk("ar_pending0", 32'(pending), 32'h00);
    chk("ar_busy",    32'(busy),    32'd0);
    chk("ar_code",    32'(code),    32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    chk("ar_after", 32'(valid), 32'd0);

    chk("sb_leftover", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
